// File: rtl/jtdd_colmix_pkg.sv
// Shared constants and helpers for the colour mixer.
package jtdd_colmix_pkg;

    // Palette region base addresses per layer
    localparam logic [8:0] PAL_CHAR_BASE = 9'h000;
    localparam logic [8:0] PAL_OBJ_BASE  = 9'h080;
    localparam logic [8:0] PAL_SCR_BASE  = 9'h100;

    // Pixel code that marks a transparent dot
    localparam logic [3:0] TRANSP_PIX = 4'hF;

    // A layer dot is opaque when its layer is enabled and its pixel code is not transparent
    function automatic logic pxl_opaque(input logic [3:0] pix, input logic en);
        return en && (pix != TRANSP_PIX);
    endfunction

endpackage

// File: rtl/jtdd_colmix_dpram.sv
// Dual-port palette bank: CPU read/write port and a read-only video port.
// Both reads are synchronous; a write and a read of the same address in one
// clock return the old contents.
module jtdd_colmix_dpram #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 8,
    parameter int unsigned QW = 8   // video port width, taken from the low bits of a word
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic          cpu_we_i,
    input  logic [DW-1:0] cpu_din_i,
    output logic [DW-1:0] cpu_q_o,
    input  logic [AW-1:0] vid_addr_i,
    output logic [QW-1:0] vid_q_o
);

    logic [DW-1:0] mem_q [2**AW];

    // Storage array: never reset, so palette survives a system reset
    always_ff @(posedge clk) begin
        if (cpu_we_i) begin
            mem_q[cpu_addr_i] <= cpu_din_i;
        end
    end

    // Read registers for both ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_q_o <= '0;
            vid_q_o <= '0;
        end else begin
            cpu_q_o <= mem_q[cpu_addr_i];
            vid_q_o <= mem_q[vid_addr_i][QW-1:0];
        end
    end

endmodule

// File: rtl/jtdd_colmix.sv
// Colour mixer: layer priority, palette lookup and blank-aligned RGB output.
module jtdd_colmix
    import jtdd_colmix_pkg::*;
#(
    parameter int unsigned BLANK_DLY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pxl_cen,
    input  logic [9:0] cpu_AB,
    input  logic       pal_cs,
    input  logic       cpu_wrn,
    input  logic [7:0] cpu_dout,
    input  logic       cen_E,
    output logic [7:0] pal_dout,
    input  logic [6:0] char_pxl,
    input  logic [7:0] obj_pxl,
    input  logic [6:0] scr_pxl,
    input  logic [2:0] gfx_en,
    input  logic       LHBL,
    input  logic       LVBL,
    output logic       LHBL_dly,
    output logic       LVBL_dly,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue
);

    logic [8:0]           idx_d, idx_q;
    logic [BLANK_DLY-1:0] lhbl_sr_q, lvbl_sr_q;
    logic                 bank_q;
    logic                 pal_we;
    logic                 we_rg, we_b;
    logic [7:0]           rg_cpu, b_cpu, rg_vid;
    logic [3:0]           b_vid;
    logic [3:0]           red_q, green_q, blue_q;

    assign pal_we = pal_cs && !cpu_wrn && cen_E;
    assign we_rg  = pal_we && !cpu_AB[9];
    assign we_b   = pal_we &&  cpu_AB[9];

    // Layer priority: char over obj over scroll; a disabled scroll layer reads as all-ones
    always_comb begin
        idx_d = PAL_SCR_BASE | {2'b00, (gfx_en[2] ? scr_pxl : 7'h7F)};
        if (pxl_opaque(char_pxl[3:0], gfx_en[0])) begin
            idx_d = PAL_CHAR_BASE | {2'b00, char_pxl};
        end else if (pxl_opaque(obj_pxl[3:0], gfx_en[1])) begin
            idx_d = PAL_OBJ_BASE | {1'b0, obj_pxl};
        end
    end

    jtdd_colmix_dpram #(.AW(9), .DW(8), .QW(8)) u_rg_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_addr_i (cpu_AB[8:0]),
        .cpu_we_i   (we_rg),
        .cpu_din_i  (cpu_dout),
        .cpu_q_o    (rg_cpu),
        .vid_addr_i (idx_q),
        .vid_q_o    (rg_vid)
    );

    jtdd_colmix_dpram #(.AW(9), .DW(8), .QW(4)) u_b_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_addr_i (cpu_AB[8:0]),
        .cpu_we_i   (we_b),
        .cpu_din_i  (cpu_dout),
        .cpu_q_o    (b_cpu),
        .vid_addr_i (idx_q),
        .vid_q_o    (b_vid)
    );

    // Remember which bank the CPU addressed so read data comes from the matching RAM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q <= 1'b0;
        end else begin
            bank_q <= cpu_AB[9];
        end
    end

    assign pal_dout = bank_q ? b_cpu : rg_cpu;

    // Pixel pipeline: stage 1 index and blank taps, stage 2 colour registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            lhbl_sr_q <= '0;
            lvbl_sr_q <= '0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
        end else if (pxl_cen) begin
            idx_q     <= idx_d;
            lhbl_sr_q <= {lhbl_sr_q[BLANK_DLY-2:0], LHBL};
            lvbl_sr_q <= {lvbl_sr_q[BLANK_DLY-2:0], LVBL};
            // Tap 0 is the blank state of the dot whose palette data is arriving now
            if (lhbl_sr_q[0] && lvbl_sr_q[0]) begin
                red_q   <= rg_vid[3:0];
                green_q <= rg_vid[7:4];
                blue_q  <= b_vid;
            end else begin
                red_q   <= '0;
                green_q <= '0;
                blue_q  <= '0;
            end
        end
    end

    assign LHBL_dly = lhbl_sr_q[BLANK_DLY-1];
    assign LVBL_dly = lvbl_sr_q[BLANK_DLY-1];
    assign red      = red_q;
    assign green    = green_q;
    assign blue     = blue_q;

endmodule

// File: tb/tb_jtdd_colmix.sv
// Directed bench for the colour mixer: priority, transparency, blanking,
// write/read collision and reset behaviour.
module tb_jtdd_colmix;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pxl_cen = 1'b0;
    logic [9:0] cpu_AB = '0;
    logic       pal_cs = 1'b0;
    logic       cpu_wrn = 1'b1;
    logic [7:0] cpu_dout = '0;
    logic       cen_E = 1'b0;
    logic [7:0] pal_dout;
    logic [6:0] char_pxl = 7'h0F;
    logic [7:0] obj_pxl = 8'h0F;
    logic [6:0] scr_pxl = 7'h0F;
    logic [2:0] gfx_en = 3'b111;
    logic       LHBL = 1'b1;
    logic       LVBL = 1'b1;
    logic       LHBL_dly, LVBL_dly;
    logic [3:0] red, green, blue;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jtdd_colmix #(.BLANK_DLY(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pxl_cen  (pxl_cen),
        .cpu_AB   (cpu_AB),
        .pal_cs   (pal_cs),
        .cpu_wrn  (cpu_wrn),
        .cpu_dout (cpu_dout),
        .cen_E    (cen_E),
        .pal_dout (pal_dout),
        .char_pxl (char_pxl),
        .obj_pxl  (obj_pxl),
        .scr_pxl  (scr_pxl),
        .gfx_en   (gfx_en),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .LHBL_dly (LHBL_dly),
        .LVBL_dly (LVBL_dly),
        .red      (red),
        .green    (green),
        .blue     (blue)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rgb();
        return {20'd0, red, green, blue};
    endfunction

    task automatic pal_write(input logic bank, input logic [8:0] idx, input logic [7:0] data);
        @(negedge clk);
        cpu_AB = {bank, idx}; cpu_dout = data; pal_cs = 1'b1; cpu_wrn = 1'b0; cen_E = 1'b1;
        @(negedge clk);
        pal_cs = 1'b0; cpu_wrn = 1'b1; cen_E = 1'b0;
    endtask

    task automatic pal_read(input logic bank, input logic [8:0] idx, output logic [7:0] data);
        @(negedge clk);
        cpu_AB = {bank, idx};
        @(negedge clk);
        data = pal_dout;
    endtask

    // One dot: a single-clock pxl_cen pulse, then idle clocks for the RAM read
    task automatic tick();
        @(negedge clk);
        pxl_cen = 1'b1;
        @(negedge clk);
        pxl_cen = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // CPU palette write landing on the same clock as a pixel enable
    task automatic tick_write(input logic bank, input logic [8:0] idx, input logic [7:0] data);
        @(negedge clk);
        cpu_AB = {bank, idx}; cpu_dout = data; pal_cs = 1'b1; cpu_wrn = 1'b0; cen_E = 1'b1;
        pxl_cen = 1'b1;
        @(negedge clk);
        pal_cs = 1'b0; cpu_wrn = 1'b1; cen_E = 1'b0; pxl_cen = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic show(input logic [6:0] c, input logic [7:0] o, input logic [6:0] s,
                        input logic [2:0] en);
        char_pxl = c; obj_pxl = o; scr_pxl = s; gfx_en = en;
        tick();
        tick();
    endtask

    logic [7:0] rd;
    logic [7:0] hb_pat;

    initial begin
        // Reset state
        #1;
        check("reset_rgb", rgb(), 32'h000);
        check("reset_lhbl_dly", {31'd0, LHBL_dly}, 32'd0);
        check("reset_lvbl_dly", {31'd0, LVBL_dly}, 32'd0);
        check("reset_pal_dout", {24'd0, pal_dout}, 32'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Palette preload
        pal_write(1'b0, 9'h000, 8'h00); pal_write(1'b1, 9'h000, 8'h00);
        pal_write(1'b0, 9'h012, 8'hA5); pal_write(1'b1, 9'h012, 8'h03);
        pal_write(1'b0, 9'h0A1, 8'h12); pal_write(1'b1, 9'h0A1, 8'h04);
        pal_write(1'b0, 9'h105, 8'h67); pal_write(1'b1, 9'h105, 8'h08);
        pal_write(1'b0, 9'h17F, 8'h9C); pal_write(1'b1, 9'h17F, 8'h0E);
        pal_write(1'b0, 9'h180, 8'h3C); pal_write(1'b1, 9'h180, 8'h0D);

        // Write gated by cen_E: this must not land
        @(negedge clk);
        cpu_AB = {1'b0, 9'h012}; cpu_dout = 8'hFF; pal_cs = 1'b1; cpu_wrn = 1'b0; cen_E = 1'b0;
        @(negedge clk);
        pal_cs = 1'b0; cpu_wrn = 1'b1;

        pal_read(1'b0, 9'h012, rd); check("rd_rg_012", {24'd0, rd}, 32'hA5);
        pal_read(1'b1, 9'h012, rd); check("rd_b_012", {24'd0, rd}, 32'h03);
        pal_read(1'b0, 9'h180, rd); check("rd_rg_180", {24'd0, rd}, 32'h3C);
        pal_read(1'b1, 9'h180, rd); check("rd_b_180", {24'd0, rd}, 32'h0D);

        // Char opaque
        show(7'h12, 8'h0F, 7'h0F, 3'b111);
        check("char_012", rgb(), 32'h5A3);
        check("lhbl_dly_hi", {31'd0, LHBL_dly}, 32'd1);
        check("lvbl_dly_hi", {31'd0, LVBL_dly}, 32'd1);

        // Char transparent -> obj, then obj transparent -> scroll
        show(7'h1F, 8'h21, 7'h05, 3'b111);
        check("obj_0a1", rgb(), 32'h214);
        show(7'h1F, 8'h2F, 7'h05, 3'b111);
        check("scr_105", rgb(), 32'h768);

        // Layer enables
        show(7'h12, 8'h21, 7'h05, 3'b110);
        check("en110_obj", rgb(), 32'h214);
        show(7'h12, 8'h21, 7'h05, 3'b100);
        check("en100_scr", rgb(), 32'h768);
        show(7'h12, 8'h21, 7'h05, 3'b000);
        check("en000_17f", rgb(), 32'hC9E);

        // No pxl_cen: outputs hold even though inputs change
        char_pxl = 7'h21; gfx_en = 3'b111;
        repeat (6) @(negedge clk);
        check("hold_no_cen", rgb(), 32'hC9E);

        // Blanking: LHBL low for dots 2..4; output after dot k reflects dot k-1
        show(7'h12, 8'h0F, 7'h0F, 3'b111);
        hb_pat = 8'b1110_0011;
        for (int k = 0; k < 8; k++) begin
            LHBL = hb_pat[k];
            tick();
            if (k > 0) begin
                check($sformatf("blank_rgb_%0d", k), rgb(), hb_pat[k-1] ? 32'h5A3 : 32'h000);
                check($sformatf("blank_lhbl_%0d", k), {31'd0, LHBL_dly}, {31'd0, hb_pat[k-1]});
            end
        end
        LHBL = 1'b1;
        LVBL = 1'b0;
        tick();
        tick();
        check("vblank_rgb", rgb(), 32'h000);
        check("vblank_lvbl_dly", {31'd0, LVBL_dly}, 32'd0);
        LVBL = 1'b1;
        tick();
        tick();
        check("vblank_end_rgb", rgb(), 32'h5A3);

        // Collision: CPU writes 0x012 on the same clock the video side reads it
        tick_write(1'b0, 9'h012, 8'h5B);
        check("collide_old", rgb(), 32'h5A3);
        tick();
        check("collide_new", rgb(), 32'hB53);
        pal_read(1'b0, 9'h012, rd); check("rd_after_collide", {24'd0, rd}, 32'h5B);

        // Reset mid-line
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_rgb", rgb(), 32'h000);
        check("midrst_lhbl", {31'd0, LHBL_dly}, 32'd0);
        check("midrst_lvbl", {31'd0, LVBL_dly}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("postrst_lhbl_1", {31'd0, LHBL_dly}, 32'd0);
        tick();
        check("postrst_rgb_2", rgb(), 32'hB53);
        check("postrst_lhbl_2", {31'd0, LHBL_dly}, 32'd1);
        pal_read(1'b1, 9'h0A1, rd); check("postrst_rd_b_0a1", {24'd0, rd}, 32'h04);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
